// File: rtl/sig_dump_pkg.sv
// Shared types for the signature dump host: FSM states and
// the response FIFO entry.
package sig_dump_pkg;

  localparam int SdDataWidth = 32;

  typedef enum logic [1:0] {
    SdIdle,
    SdRun,
    SdDrain,
    SdDone
  } sd_state_t;

  typedef struct packed {
    logic [SdDataWidth-1:0] data;
    logic                   last;
  } sd_entry_t;

endpackage

// File: rtl/sig_dump_fifo.sv
// Synchronous response FIFO with occupancy count; a push is
// accepted at full when a pop happens in the same cycle.
module sig_dump_fifo
  import sig_dump_pkg::*;
#(
  parameter int Depth    = 4,
  parameter int CntWidth = $clog2(Depth) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push,
  input  sd_entry_t           wdata,
  input  logic                pop,
  output sd_entry_t           rdata,
  output logic [CntWidth-1:0] count,
  output logic                empty,
  output logic                full
);

  localparam int PW = $clog2(Depth);

  sd_entry_t     mem [Depth];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CntWidth'(Depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/sig_dump_host.sv
// Read-only bus host that streams a word region out of RAM
// onto a valid/ready port, with credit-based issue control.
module sig_dump_host
  import sig_dump_pkg::*;
#(
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2,
  parameter int FifoDepth      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] start_addr_i,
  input  logic [AddrWidth-1:0] end_addr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [DataWidth-1:0] host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  input  logic                 host_err_i,
  output logic                 out_valid_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i
);

  localparam int WW = AddrWidth - 2;
  localparam int OW = $clog2(MaxOutstanding + 1);
  localparam int CW = $clog2(FifoDepth) + 1;
  localparam int SW = CW + 1;

  sd_state_t     state;
  sd_state_t     next_state;
  logic [WW-1:0] start_word;
  logic [WW-1:0] end_in;
  logic [WW-1:0] issue_word;
  logic [WW-1:0] rsp_word;
  logic [WW-1:0] end_word;
  logic [OW-1:0] outs;
  logic [CW-1:0] fcount;
  logic [SW-1:0] credit;
  logic          err;
  logic          fempty;
  logic          ffull;
  sd_entry_t     fin;
  sd_entry_t     fout;
  logic          start_ok;
  logic          run_start;
  logic          grant;
  logic          rsp;
  logic          push;
  logic          pop;
  logic          last_issue;
  logic          unused_bits;

  assign start_word = start_addr_i[AddrWidth-1:2];
  assign end_in     = end_addr_i[AddrWidth-1:2];
  assign start_ok   = start_i && (state == SdIdle);
  assign run_start  = start_ok && (end_in >= start_word);

  // Credit: every granted read must already own a FIFO slot.
  assign credit     = SW'(outs) + SW'(fcount);
  assign host_req_o = (state == SdRun)
                   && (outs < OW'(MaxOutstanding))
                   && (credit < SW'(FifoDepth));

  assign grant      = host_req_o && host_gnt_i;
  assign rsp        = host_rvalid_i && (outs != '0);
  assign push       = rsp && !host_err_i && !err;
  assign last_issue = (issue_word == end_word);

  assign host_addr_o  = {issue_word, 2'b00};
  assign host_we_o    = 1'b0;
  assign host_be_o    = 4'hF;
  assign host_wdata_o = '0;
  assign err_o        = err;

  assign fin.data    = host_rdata_i;
  assign fin.last    = (rsp_word == end_word);
  assign out_valid_o = !fempty;
  assign out_data_o  = fout.data;
  assign out_last_o  = out_valid_o && fout.last;
  assign pop         = out_valid_o && out_ready_i;

  assign unused_bits = ^{start_addr_i[1:0], end_addr_i[1:0], ffull};

  sig_dump_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push (push),
    .wdata(fin),
    .pop  (pop),
    .rdata(fout),
    .count(fcount),
    .empty(fempty),
    .full (ffull)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= SdIdle;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state)
      SdIdle: begin
        if (start_i) next_state = run_start ? SdRun : SdDone;
      end
      SdRun: begin
        busy_o = 1'b1;
        if ((grant && last_issue) || (rsp && host_err_i))
          next_state = SdDrain;
      end
      SdDrain: begin
        busy_o = 1'b1;
        if ((outs == '0) && fempty) next_state = SdDone;
      end
      SdDone: begin
        done_o     = 1'b1;
        next_state = SdIdle;
      end
      default: next_state = SdIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_word <= '0;
      rsp_word   <= '0;
      end_word   <= '0;
      outs       <= '0;
      err        <= 1'b0;
    end else begin
      if (start_ok) err <= 1'b0;
      if (run_start) begin
        issue_word <= start_word;
        rsp_word   <= start_word;
        end_word   <= end_in;
      end else begin
        if (grant) issue_word <= issue_word + WW'(1);
        if (rsp)   rsp_word   <= rsp_word + WW'(1);
        if (rsp && host_err_i) err <= 1'b1;
      end
      case ({grant, rsp})
        2'b10:   outs <= outs + OW'(1);
        2'b01:   outs <= outs - OW'(1);
        default: outs <= outs;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_dump_host.sv
// Bench for sig_dump_host: RAM/bus responder, output sink and
// a region-level reference model of the expected word stream.
module tb_sig_dump_host;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] start_addr_i = '0;
  logic [31:0] end_addr_i = '0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        host_req_o;
  logic        host_gnt_i = 1'b0;
  logic [31:0] host_addr_o;
  logic        host_we_o;
  logic [3:0]  host_be_o;
  logic [31:0] host_wdata_o;
  logic        host_rvalid_i = 1'b0;
  logic [31:0] host_rdata_i = '0;
  logic        host_err_i = 1'b0;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic        out_ready_i = 1'b0;

  sig_dump_host dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .end_addr_i   (end_addr_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .host_req_o   (host_req_o),
    .host_gnt_i   (host_gnt_i),
    .host_addr_o  (host_addr_o),
    .host_we_o    (host_we_o),
    .host_be_o    (host_be_o),
    .host_wdata_o (host_wdata_o),
    .host_rvalid_i(host_rvalid_i),
    .host_rdata_i (host_rdata_i),
    .host_err_i   (host_err_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .out_ready_i  (out_ready_i)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [16384];
  logic [31:0] pend_q [$];
  logic [31:0] gnt_log [$];
  logic [31:0] got_data [$];
  bit          got_last [$];
  int  gnt_mode = 0;
  bit  rsp_rand = 0;
  bit  rsp_hold = 0;
  bit  sink_rand = 0;
  bit  sink_ready = 1;
  int  err_at = -1;
  int  rsp_idx = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  req_seen = 0;
  int  stab_err = 0;
  bit  prev_wait = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] a;

  int vectors = 0;
  int miscompares = 0;
  int done_base = 0;
  int req_base = 0;
  int start_cyc = 0;

  // Bus responder and sink, evaluated away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (host_req_o) req_seen++;
    if (!rst_i && prev_wait &&
        (!host_req_o || host_addr_o != prev_addr))
      stab_err++;
    out_ready_i = sink_rand ? ($urandom % 2 == 1) : sink_ready;
    if (!rst_i && out_valid_o && out_ready_i) begin
      got_data.push_back(out_data_o);
      got_last.push_back(out_last_o);
    end
    host_rvalid_i = 1'b0;
    host_err_i    = 1'b0;
    host_rdata_i  = $urandom;
    if (pend_q.size() > 0 && !rsp_hold &&
        (!rsp_rand || $urandom % 2 == 0)) begin
      a = pend_q.pop_front();
      host_rvalid_i = 1'b1;
      host_rdata_i  = ram[a[15:2]];
      host_err_i    = (rsp_idx == err_at);
      rsp_idx++;
    end
    case (gnt_mode)
      0:       host_gnt_i = 1'b1;
      1:       host_gnt_i = ($urandom % 2 == 1);
      default: host_gnt_i = 1'b0;
    endcase
    if (!rst_i && host_req_o && host_gnt_i) begin
      pend_q.push_back(host_addr_o);
      gnt_log.push_back(host_addr_o);
    end
    prev_wait = host_req_o && !host_gnt_i;
    prev_addr = host_addr_o;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input logic [31:0] s,
                            input logic [31:0] e);
    gnt_log.delete();
    got_data.delete();
    got_last.delete();
    rsp_idx      = 0;
    done_base    = done_cnt;
    req_base     = req_seen;
    start_addr_i = s;
    end_addr_i   = e;
    start_i      = 1'b1;
    @(posedge clk);
    start_cyc = cyc;
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({tag, "_done"}, 64'(done_cnt != done_base), 64'd1);
  endtask

  // Reference: words s..s+n-1 of RAM in order, last on the
  // final one only when the region completes normally.
  task automatic check_words(input string tag, input int s,
                             input int n, input bit has_last);
    int bad = 0;
    chk({tag, "_count"}, 64'(got_data.size()), 64'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      if (got_data[i] !== ram[s+i]) bad++;
      if (got_last[i] !== (has_last && i == n - 1)) bad++;
    end
    chk({tag, "_words"}, 64'(bad), 64'd0);
  endtask

  task automatic check_grants(input string tag, input int s,
                              input int n);
    int bad = 0;
    chk({tag, "_gnts"}, 64'(gnt_log.size()), 64'(n));
    for (int i = 0; i < n && i < gnt_log.size(); i++)
      if (gnt_log[i] !== 32'((s + i) * 4)) bad++;
    chk({tag, "_gaddr"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int s;
    int len;
    for (int i = 0; i < 16384; i++) ram[i] = $urandom;
    for (int i = 0; i < 4; i++) ram[16'h40 + i] = 32'hA0 + 32'(i);

    cycle(3);
    chk("rst_req", 64'(host_req_o), 64'd0);
    chk("rst_addr", 64'(host_addr_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_last", 64'(out_last_o), 64'd0);
    chk("tie_we", 64'(host_we_o), 64'd0);
    chk("tie_be", 64'(host_be_o), 64'hF);
    chk("tie_wdata", 64'(host_wdata_o), 64'd0);
    rst_i = 1'b0;
    cycle(2);

    // Basic four-word dump.
    start_dump(32'h100, 32'h10C);
    wait_done("basic", 100);
    check_words("basic", 'h40, 4, 1);
    check_grants("basic", 'h40, 4);
    if (got_data.size() == 4) begin
      chk("basic_w0", 64'(got_data[0]), 64'hA0);
      chk("basic_w3", 64'(got_data[3]), 64'hA3);
      chk("basic_l2", 64'(got_last[2]), 64'd0);
      chk("basic_l3", 64'(got_last[3]), 64'd1);
    end
    chk("basic_err", 64'(err_o), 64'd0);
    cycle(3);
    chk("basic_pulse", 64'(done_cnt - done_base), 64'd1);
    chk("basic_idle", 64'(busy_o), 64'd0);

    // Backpressure: credit stops issue at four words in flight.
    sink_ready = 0;
    start_dump(32'h100, 32'h10C);
    cycle(20);
    chk("bp4_gnts", 64'(gnt_log.size()), 64'd4);
    chk("bp4_none", 64'(got_data.size()), 64'd0);
    chk("bp4_busy", 64'(busy_o), 64'd1);
    sink_ready = 1;
    wait_done("bp4", 100);
    check_words("bp4", 'h40, 4, 1);

    sink_ready = 0;
    start_dump(32'h300, 32'h31C);
    cycle(20);
    chk("bp8_gnts", 64'(gnt_log.size()), 64'd4);
    chk("bp8_valid", 64'(out_valid_o), 64'd1);
    sink_ready = 1;
    wait_done("bp8", 100);
    check_words("bp8", 'hC0, 8, 1);
    check_grants("bp8", 'hC0, 8);

    // Empty region: end below start.
    start_dump(32'h200, 32'h1FC);
    wait_done("empty", 10);
    chk("empty_lat_ok",
        64'((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2),
        64'd1);
    cycle(3);
    chk("empty_req", 64'(req_seen - req_base), 64'd0);
    chk("empty_out", 64'(got_data.size()), 64'd0);

    // Error on the third response.
    err_at = 2;
    start_dump(32'h0, 32'h10);
    wait_done("err", 100);
    chk("err_flag", 64'(err_o), 64'd1);
    check_words("err", 0, 2, 0);
    err_at = -1;
    cycle(3);
    chk("err_sticky", 64'(err_o), 64'd1);

    // Reset with two reads outstanding; also clears err on start.
    rsp_hold = 1;
    start_dump(32'h100, 32'h10C);
    chk("err_clear", 64'(err_o), 64'd0);
    cycle(5);
    chk("rst_outs", 64'(gnt_log.size()), 64'd2);
    rst_i = 1'b1;
    cycle(1);
    chk("rst_drop", 64'(host_req_o), 64'd0);
    cycle(1);
    rst_i    = 1'b0;
    rsp_hold = 0;
    got_data.delete();
    got_last.delete();
    cycle(6);
    chk("stale_gone", 64'(pend_q.size()), 64'd0);
    chk("stale_out", 64'(got_data.size()), 64'd0);
    chk("stale_valid", 64'(out_valid_o), 64'd0);
    start_dump(32'h40, 32'h40);
    wait_done("one", 50);
    check_words("one", 'h10, 1, 1);

    // Grant held low: request stable, mid-dump start ignored.
    gnt_mode = 2;
    start_dump(32'h100, 32'h10C);
    cycle(5);
    chk("hold_req", 64'(host_req_o), 64'd1);
    chk("hold_addr", 64'(host_addr_o), 64'h100);
    chk("hold_gnts", 64'(gnt_log.size()), 64'd0);
    start_addr_i = 32'h0;
    end_addr_i   = 32'h3C;
    start_i      = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    cycle(2);
    chk("hold_stable", 64'(stab_err), 64'd0);
    gnt_mode = 0;
    wait_done("hold", 100);
    cycle(10);
    chk("hold_pulses", 64'(done_cnt - done_base), 64'd1);
    check_words("hold", 'h40, 4, 1);
    chk("hold_idle", 64'(busy_o), 64'd0);

    // Whole 64 kB region.
    start_dump(32'h0, 32'hFFFC);
    wait_done("full", 40000);
    check_words("full", 0, 16384, 1);

    // Randomized regions with random grant, latency and sink.
    gnt_mode  = 1;
    rsp_rand  = 1;
    sink_rand = 1;
    for (int k = 0; k < 6; k++) begin
      s   = $urandom_range(0, 16000);
      len = $urandom_range(1, 12);
      start_dump(32'(s * 4), 32'((s + len - 1) * 4));
      wait_done("rand", 600);
      check_words("rand", s, len, 1);
      check_grants("rand", s, len);
      cycle(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
